// File: rtl/dmem_wait_ctrl_pkg.sv
// rtl/dmem_wait_ctrl_pkg.sv - shared FSM encoding, counter width and defaults for dmem_wait_ctrl
package dmem_wait_ctrl_pkg;

  // Width of the access / drain down-counters (WAIT_STATES up to 15).
  localparam int CNT_W               = 4;
  localparam int DEFAULT_WAIT_STATES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Loads always fetch the full word; stores use the requested lanes.
  function automatic logic [3:0] access_lanes(input logic is_load, input logic [3:0] be);
    return is_load ? 4'hF : be;
  endfunction

endpackage

// File: rtl/dmem_wait_cnt.sv
// rtl/dmem_wait_cnt.sv - loadable 4-bit down-counter with zero flag
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset (count cleared)
//   load_i     load load_val_i (has priority over dec_i)
//   load_val_i value to load
//   dec_i      decrement by one; holds at zero, never wraps
//   zero_o     1 when the count is zero
module dmem_wait_cnt
  import dmem_wait_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dmem_wait_ctrl.sv
// rtl/dmem_wait_ctrl.sv - MEM-stage data-memory responder driving a fixed-latency RAM and the dmem_wait stall
// Optional feature macro: DMEM_WBUF_EN (one-entry posted write buffer).
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   enable                global run enable; gates new launches only
//   MemRead, MemWrite     level requests from MEM stage (MemRead wins if both set)
//   Address, WriteData    request byte address and store data
//   ByteEn                store byte lanes
//   ReadData              load result, valid in the cycle dmem_wait falls, held until next load
//   dmem_wait             pipeline freeze, combinational from the request in IDLE
//   ram_cs, ram_we        RAM select / write strobe, registered, held for the whole access
//   ram_addr, ram_wdata   registered address / store data
//   ram_be                registered lanes (4'hF for loads)
//   ram_rdata             RAM read data, sampled at the end of the last BUSY cycle
module dmem_wait_ctrl
  import dmem_wait_ctrl_pkg::*;
#(
  parameter int WAIT_STATES = DEFAULT_WAIT_STATES,
  parameter int AW          = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic [AW-1:0] Address,
  input  logic [31:0]   WriteData,
  input  logic [3:0]    ByteEn,
  output logic [31:0]   ReadData,
  output logic          dmem_wait,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  output logic [3:0]    ram_be,
  input  logic [31:0]   ram_rdata
);

  localparam logic [CNT_W-1:0] LAUNCH_CNT = CNT_W'(WAIT_STATES - 1);

  state_e        state_q, state_d;
  logic          ram_cs_q, ram_cs_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]   ram_wdata_q, ram_wdata_d;
  logic [3:0]    ram_be_q, ram_be_d;
  logic [31:0]   rdata_q, rdata_d;

  logic req;
  logic launch;      // start a stalling access this cycle
  logic post;        // accept a store into the write buffer this cycle
  logic capture;     // last BUSY cycle of a load
  logic cnt_zero;
  logic wb_busy;     // write buffer is draining
  logic drain_done;  // last drain cycle

  // Gating with rst keeps dmem_wait low while reset is held, even with a request pending.
  assign req = rst & enable & (MemRead | MemWrite);

  always_comb begin
    state_d   = state_q;
    dmem_wait = 1'b0;
    launch    = 1'b0;
    post      = 1'b0;
    capture   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (wb_busy) begin
            dmem_wait = 1'b1;
`ifdef DMEM_WBUF_EN
          end else if (!MemRead) begin
            post = 1'b1;
`endif
          end else begin
            dmem_wait = 1'b1;
            launch    = 1'b1;
            state_d   = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        dmem_wait = 1'b1;
        if (cnt_zero) begin
          capture = ~ram_we_q;
          state_d = ST_DONE;
        end
      end
      // The request still held by the finishing instruction is ignored here.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  dmem_wait_cnt u_access_cnt (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (launch),
    .load_val_i (LAUNCH_CNT),
    .dec_i      (state_q == ST_BUSY),
    .zero_o     (cnt_zero)
  );

`ifdef DMEM_WBUF_EN
  // Drain runs WAIT_STATES+1 cycles after the post: counts WAIT_STATES..0.
  localparam logic [CNT_W-1:0] DRAIN_CNT = CNT_W'(WAIT_STATES);

  logic wb_busy_q, wb_busy_d;
  logic drain_zero;

  assign wb_busy    = wb_busy_q;
  assign drain_done = wb_busy_q & drain_zero;

  always_comb begin
    wb_busy_d = wb_busy_q;
    if (post) begin
      wb_busy_d = 1'b1;
    end else if (drain_done) begin
      wb_busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_busy_q <= 1'b0;
    end else begin
      wb_busy_q <= wb_busy_d;
    end
  end

  dmem_wait_cnt u_drain_cnt (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (post),
    .load_val_i (DRAIN_CNT),
    .dec_i      (wb_busy_q),
    .zero_o     (drain_zero)
  );
`else
  assign wb_busy    = 1'b0;
  assign drain_done = 1'b0;
`endif

  // RAM side: raised at the launch edge, dropped at the edge leaving DONE (or end of drain),
  // so the select covers the BUSY cycles plus the DONE cycle.
  always_comb begin
    ram_cs_d    = ram_cs_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_be_d    = ram_be_q;
    rdata_d     = rdata_q;
    if (launch || post) begin
      ram_cs_d    = 1'b1;
      ram_we_d    = ~MemRead;
      ram_addr_d  = Address;
      ram_wdata_d = WriteData;
      ram_be_d    = access_lanes(MemRead, ByteEn);
    end else if ((state_q == ST_DONE) || drain_done) begin
      ram_cs_d = 1'b0;
      ram_we_d = 1'b0;
    end
    if (capture) begin
      rdata_d = ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_be_q    <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ram_cs_q    <= ram_cs_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_be_q    <= ram_be_d;
      rdata_q     <= rdata_d;
    end
  end

  assign ram_cs    = ram_cs_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_be    = ram_be_q;
  assign ReadData  = rdata_q;

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// tb/tb_dmem_wait_ctrl.sv - self-checking bench for dmem_wait_ctrl (default build and DMEM_WBUF_EN)
module tb_dmem_wait_ctrl;
  localparam int WS = 2;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          MemRead = 1'b0;
  logic          MemWrite = 1'b0;
  logic [AW-1:0] Address = '0;
  logic [31:0]   WriteData = '0;
  logic [3:0]    ByteEn = '0;
  logic [31:0]   ReadData;
  logic          dmem_wait;
  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [3:0]    ram_be;
  logic [31:0]   ram_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int cs_bursts = 0;
  logic cs_prev = 1'b0;

  // Environment RAM
  logic [31:0] ram [0:255];
  // Reference model state
  logic [31:0] ref_mem [0:255];
  logic [31:0] ref_rd = '0;
  int free_at = 0;

  dmem_wait_ctrl #(.WAIT_STATES(WS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ByteEn(ByteEn), .ReadData(ReadData),
    .dmem_wait(dmem_wait), .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign ram_rdata = ram[ram_addr[9:2]];
  always @(posedge clk) begin
    if (ram_cs === 1'b1 && ram_we === 1'b1)
      for (int i = 0; i < 4; i++)
        if (ram_be[i]) ram[ram_addr[9:2]][8*i +: 8] <= ram_wdata[8*i +: 8];
  end

  always @(negedge clk) begin
    if (ram_cs === 1'b1 && cs_prev !== 1'b1) cs_bursts++;
    cs_prev = ram_cs;
  end

  // Predicts the stall length and ReadData of one instruction issued at cycle c.
  task automatic model_access(input bit ld, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] be, input int c, output int st, output logic [31:0] rdv);
`ifdef DMEM_WBUF_EN
    int start;
    start = (free_at > c) ? free_at : c;
    if (ld) st = start - c + WS + 1;
    else begin
      st = start - c;
      free_at = start + WS + 2;
    end
`else
    st = WS + 1;
`endif
    if (ld) ref_rd = ref_mem[a[9:2]];
    else for (int i = 0; i < 4; i++) if (be[i]) ref_mem[a[9:2]][8*i +: 8] = wd[8*i +: 8];
    rdv = ref_rd;
  endtask

  // Presents one instruction and holds it until the pipeline would advance; returns observations.
  task automatic access(input bit ld, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                        output int stall, output int cs_n, output bit sig_ok,
                        output logic [31:0] rd, output logic cs_after);
    MemRead = ld; MemWrite = !ld; Address = a; WriteData = wd; ByteEn = be;
    #1;
    stall = 0; cs_n = 0; sig_ok = 1'b1;
    while (dmem_wait === 1'b1 && stall < 64) begin
      @(posedge clk); #1;
      stall++;
      if (ram_cs === 1'b1) begin
        cs_n++;
        if (ram_we !== !ld || ram_addr !== a || ram_be !== (ld ? 4'hF : be) || (!ld && ram_wdata !== wd))
          sig_ok = 1'b0;
      end
    end
    rd = ReadData;
    @(posedge clk); #1;
    cs_after = ram_cs;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b1; MemRead = 1'b1; Address = 32'h40;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (dmem_wait !== 1'b0) begin n_bad++; $display("FAIL reset_wait: got %b want 0", dmem_wait); end
    n_cmp++; if ({ram_cs, ram_we, ram_be} !== 6'b0) begin n_bad++; $display("FAIL reset_ram_ctl: got %b want 0", {ram_cs, ram_we, ram_be}); end
    n_cmp++; if ({ram_addr, ram_wdata, ReadData} !== 96'b0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {ram_addr, ram_wdata, ReadData}); end
    MemRead = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({dmem_wait, ram_cs} !== 2'b00) begin n_bad++; $display("FAIL reset_idle: got %b want 00", {dmem_wait, ram_cs}); end
  endtask

  task automatic test_load();
    int st, cs_n, est; bit ok; logic [31:0] rd, erd; logic ca;
    model_access(1'b1, 32'h40, 32'h0, 4'h0, cyc, est, erd);
    access(1'b1, 32'h40, 32'h0, 4'h0, st, cs_n, ok, rd, ca);
    n_cmp++; if (st !== est) begin n_bad++; $display("FAIL load_stall: got %0d want %0d", st, est); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_data: got %h want deadbeef", rd); end
    n_cmp++; if (cs_n !== WS + 1) begin n_bad++; $display("FAIL load_cs_len: got %0d want %0d", cs_n, WS + 1); end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL load_ram_sig: got %b want 1", ok); end
    n_cmp++; if (ca !== 1'b0) begin n_bad++; $display("FAIL load_cs_after: got %b want 0", ca); end
  endtask

  task automatic test_store();
    int st, cs_n, est; bit ok; logic [31:0] rd, erd; logic ca;
    model_access(1'b0, 32'h44, 32'h12345678, 4'b0011, cyc, est, erd);
    access(1'b0, 32'h44, 32'h12345678, 4'b0011, st, cs_n, ok, rd, ca);
    n_cmp++; if (st !== est) begin n_bad++; $display("FAIL store_stall: got %0d want %0d", st, est); end
    n_cmp++; if (rd !== erd) begin n_bad++; $display("FAIL store_rd_hold: got %h want %h", rd, erd); end
`ifndef DMEM_WBUF_EN
    n_cmp++; if (cs_n !== WS + 1) begin n_bad++; $display("FAIL store_we_len: got %0d want %0d", cs_n, WS + 1); end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL store_ram_sig: got %b want 1", ok); end
`endif
    model_access(1'b1, 32'h44, 32'h0, 4'h0, cyc, est, erd);
    access(1'b1, 32'h44, 32'h0, 4'h0, st, cs_n, ok, rd, ca);
    n_cmp++; if (st !== est) begin n_bad++; $display("FAIL readback_stall: got %0d want %0d", st, est); end
    n_cmp++; if (rd !== 32'h00005678) begin n_bad++; $display("FAIL readback_data: got %h want 00005678", rd); end
  endtask

  task automatic test_back_to_back();
    int st1, st2, cs1, cs2, e1, e2, b0; bit ok1, ok2; logic [31:0] r1, r2, er1, er2; logic ca1, ca2;
    b0 = cs_bursts;
    model_access(1'b1, 32'h40, 32'h0, 4'h0, cyc, e1, er1);
    access(1'b1, 32'h40, 32'h0, 4'h0, st1, cs1, ok1, r1, ca1);
    model_access(1'b1, 32'h48, 32'h0, 4'h0, cyc, e2, er2);
    access(1'b1, 32'h48, 32'h0, 4'h0, st2, cs2, ok2, r2, ca2);
    n_cmp++; if (cs_bursts - b0 !== 2) begin n_bad++; $display("FAIL b2b_bursts: got %0d want 2", cs_bursts - b0); end
    n_cmp++; if ({cs1, cs2} !== {WS + 1, WS + 1}) begin n_bad++; $display("FAIL b2b_cs_len: got %0d,%0d want %0d", cs1, cs2, WS + 1); end
    n_cmp++; if ({st1, st2} !== {e1, e2}) begin n_bad++; $display("FAIL b2b_stall: got %0d,%0d want %0d,%0d", st1, st2, e1, e2); end
    n_cmp++; if ({r1, r2} !== {er1, er2}) begin n_bad++; $display("FAIL b2b_data: got %h,%h want %h,%h", r1, r2, er1, er2); end
    n_cmp++; if ({ca1, ca2} !== 2'b00) begin n_bad++; $display("FAIL b2b_dup: got %b want 00", {ca1, ca2}); end
  endtask

  task automatic test_enable();
    int st, cs_n, est; bit ok; logic [31:0] rd, erd; logic ca;
    enable = 1'b0; MemRead = 1'b1; Address = 32'h48;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if ({dmem_wait, ram_cs} !== 2'b00) begin n_bad++; $display("FAIL enable_block: got %b want 00", {dmem_wait, ram_cs}); end
      @(posedge clk); #1;
    end
    enable = 1'b1;
    #1;
    n_cmp++; if (dmem_wait !== 1'b1) begin n_bad++; $display("FAIL enable_launch: got %b want 1", dmem_wait); end
    model_access(1'b1, 32'h48, 32'h0, 4'h0, cyc, est, erd);
    access(1'b1, 32'h48, 32'h0, 4'h0, st, cs_n, ok, rd, ca);
    n_cmp++; if ({st, rd} !== {est, erd}) begin n_bad++; $display("FAIL enable_access: got %0d/%h want %0d/%h", st, rd, est, erd); end
  endtask

`ifdef DMEM_WBUF_EN
  task automatic test_wbuf();
    int st, cs_n, est; bit ok; logic [31:0] rd, erd; logic ca;
    repeat (WS + 3) @(posedge clk);
    #1;
    model_access(1'b0, 32'h50, 32'hCAFEF00D, 4'hF, cyc, est, erd);
    access(1'b0, 32'h50, 32'hCAFEF00D, 4'hF, st, cs_n, ok, rd, ca);
    n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL wbuf_post_stall: got %0d want 0", st); end
    n_cmp++; if (ca !== 1'b1) begin n_bad++; $display("FAIL wbuf_draining: got %b want 1", ca); end
    model_access(1'b1, 32'h50, 32'h0, 4'h0, cyc, est, erd);
    access(1'b1, 32'h50, 32'h0, 4'h0, st, cs_n, ok, rd, ca);
    n_cmp++; if (st !== 2 * (WS + 1)) begin n_bad++; $display("FAIL wbuf_load_stall: got %0d want %0d", st, 2 * (WS + 1)); end
    n_cmp++; if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL wbuf_load_data: got %h want cafef00d", rd); end
  endtask
`endif

  task automatic test_reset_mid();
    int st, cs_n, est; bit ok; logic [31:0] rd, erd; logic ca;
    MemRead = 1'b1; Address = 32'h40;
    @(posedge clk); #1;
    n_cmp++; if (ram_cs !== 1'b1) begin n_bad++; $display("FAIL midrst_busy: got %b want 1", ram_cs); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({dmem_wait, ram_cs, ReadData} !== 34'b0) begin n_bad++; $display("FAIL midrst_clear: got %b/%b/%h want 0", dmem_wait, ram_cs, ReadData); end
    @(posedge clk); #1;
    MemRead = 1'b0; rst = 1'b1;
    ref_rd = '0; free_at = 0;
    @(posedge clk); #1;
    n_cmp++; if ({dmem_wait, ram_cs, ReadData} !== 34'b0) begin n_bad++; $display("FAIL midrst_idle: got %b/%b/%h want 0", dmem_wait, ram_cs, ReadData); end
    model_access(1'b1, 32'h40, 32'h0, 4'h0, cyc, est, erd);
    access(1'b1, 32'h40, 32'h0, 4'h0, st, cs_n, ok, rd, ca);
    n_cmp++; if ({st, rd} !== {est, erd}) begin n_bad++; $display("FAIL midrst_after: got %0d/%h want %0d/%h", st, rd, est, erd); end
  endtask

  task automatic test_random();
    int st, cs_n, est; bit ok, ld; logic [31:0] rd, erd, a, wd; logic [3:0] be; logic ca;
    for (int n = 0; n < 40; n++) begin
      ld = 1'($urandom_range(0, 1));
      a  = 32'h80 + {26'b0, 4'($urandom_range(0, 15)), 2'b00};
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      model_access(ld, a, wd, be, cyc, est, erd);
      access(ld, a, wd, be, st, cs_n, ok, rd, ca);
      n_cmp++; if (st !== est) begin n_bad++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", n, st, est); end
      n_cmp++; if (rd !== erd) begin n_bad++; $display("FAIL rnd_data[%0d]: got %h want %h", n, rd, erd); end
`ifndef DMEM_WBUF_EN
      n_cmp++; if ({cs_n, ok, ca} !== {WS + 1, 1'b1, 1'b0}) begin n_bad++; $display("FAIL rnd_ram[%0d]: got cs=%0d sig=%b after=%b", n, cs_n, ok, ca); end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    ram[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
    ram[18] = 32'h0BADCAFE; ref_mem[18] = 32'h0BADCAFE;
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_enable();
`ifdef DMEM_WBUF_EN
    test_wbuf();
`endif
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
